matvec_out_serializer: RTL and testbench
========================================

Name: matvec_out_serializer

Overview:
- Downstream stage of matvec_mul: captures one R-element result vector y (W_Y bits per element) per handshake.
- Applies optional ReLU, rounding arithmetic right shift and saturation to W_O bits to each element.
- Streams the R elements out one per beat on a valid/ready interface, element 0 first, with end-of-vector marker.
- Back-to-back vectors are sustained at R beats per vector with no bubble.

Parameters:
- R, 2, number of elements per vector (rows of matvec_mul); R >= 1.
- W_Y, 10, input element width (signed); matches matvec_mul output width W_X+W_K+$clog2(C).
- W_O, 4, output element width (signed); W_O <= W_Y.
- SHIFT, 2, arithmetic right-shift amount applied before saturation; 0 <= SHIFT < W_Y.
- RELU, 0, 1 = clamp negative elements to 0 before shift; 0 = pass through.

Ports:
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- s_valid  in  1  input vector valid.
- s_ready  out  1  block can accept a vector this cycle.
- s_data  in  [R-1:0][W_Y-1:0] signed  result vector from matvec_mul.
- m_valid  out  1  output element valid.
- m_ready  in  1  downstream accepts element.
- m_data  out  W_O signed  processed element.
- m_last  out  1  high on the beat carrying element R-1.
- m_sat  out  1  high when the current m_data was saturated.

Behaviour:
- Reset (rstn low, async): state IDLE, idx=0, m_valid=0, m_last=0, m_sat=0, s_ready=1 after reset; held vector contents don't-care. Reset mid-vector discards remaining elements; no partial beats after reset release.
- States: IDLE (no vector held), SEND (vector held, presenting element idx).
- IDLE: s_ready=1; s_valid=1 -> capture s_data into holding register, idx=0, go SEND. m_valid asserted the next cycle (1-cycle latency input to first beat).
- SEND: m_valid=1; m_data/m_last/m_sat derived only from registered vector and idx (no combinational path from s_data or s_valid).
- Beat accepted (m_valid & m_ready) with idx<R-1: idx++.
- Last beat accepted (idx=R-1): if s_valid same cycle -> capture new vector, idx=0, stay SEND (no bubble); else go IDLE.
- s_ready = (state==IDLE) | (state==SEND & idx==R-1 & m_ready). Combinational dependence of s_ready on m_ready is permitted.
- No m_ready -> m_data, m_last, m_sat, m_valid held stable; m_valid never deasserts without a handshake.
- R=1: every beat has m_last=1.
- Element arithmetic, in order, all signed:
  - v = RELU ? max(y,0) : y.
  - If SHIFT>0: v = (v + 2^(SHIFT-1)) >>> SHIFT, with round half toward +inf; compute at W_Y+1 bits so the add cannot overflow.
  - Saturate to [-2^(W_O-1), 2^(W_O-1)-1]; m_sat=1 iff clamping occurred.
- s_data changes while not handshaking have no effect.

Test Plan:
- Defaults, y=(13,-7), m_ready=1 -> beats 3 (last=0), -2 (last=1), m_sat=0 both; first m_valid exactly 1 cycle after s_valid handshake.
- y=(100,-100) -> 7 with m_sat=1, then -8 with m_sat=1, m_last on second.
- RELU=1, y=(-7,6) -> 0, 2 (6+2=8>>>2), m_sat=0.
- Backpressure: m_ready toggles 1,0,0,1 over 10 random vectors, s_valid always high -> m_data/m_last stable while m_ready=0. s_ready high only in IDLE or on accepted last beat; reference-model match for every beat, zero dropped or duplicated elements.
- Streaming: m_ready=1, s_valid=1 continuously for 8 vectors -> m_valid high every cycle after first, exactly 16 beats in 16 cycles, m_last every 2nd beat.
- rstn pulsed low asynchronously (mid-clock) while idx=0 in SEND -> m_valid=0 immediately. After release s_ready=1 and next vector's element 0 emitted first.

Source files
------------

// File: rtl/matvec_out_serializer.sv
// matvec_out_serializer
//   Takes one R-element result vector from matvec_mul per handshake, applies
//   optional ReLU, a rounding arithmetic right shift and saturation to W_O bits
//   per element, and streams the elements out one per beat, element 0 first.
//   The last beat of a vector can capture the next vector in the same cycle,
//   so back-to-back vectors stream at R beats per vector with no bubble.
// Ports
//   clk, rstn          clock, async active-low reset
//   s_valid/s_ready    input vector handshake, s_data = R x W_Y signed elements
//   m_valid/m_ready    output element handshake
//   m_data             processed element (W_O signed)
//   m_last             high on element R-1
//   m_sat              high when m_data was clamped

// Per-element arithmetic: ReLU -> round-half-up shift -> saturate.
module matvec_out_serializer_lane #(
  parameter int W_Y   = 10,
  parameter int W_O   = 4,
  parameter int SHIFT = 2,
  parameter int RELU  = 0
) (
  input  logic [W_Y-1:0] y,
  output logic [W_O-1:0] q,
  output logic           sat
);
  // Rounding constant 2^(SHIFT-1), collapses to 0 when SHIFT==0.
  localparam logic signed [W_Y:0] RND  = ((W_Y+1)'(1) << SHIFT) >>> 1;
  localparam logic signed [W_Y:0] MAXV = (W_Y+1)'((1 << (W_O-1)) - 1);
  localparam logic signed [W_Y:0] MINV = -MAXV - (W_Y+1)'(1);

  // One guard bit so the rounding add cannot overflow.
  logic signed [W_Y:0] v, r;

  always_comb begin
    v   = {y[W_Y-1], y};
    if (RELU != 0 && y[W_Y-1]) v = '0;
    r   = (v + RND) >>> SHIFT;
    q   = r[W_O-1:0];
    sat = 1'b0;
    if (r > MAXV) begin
      q   = MAXV[W_O-1:0];
      sat = 1'b1;
    end else if (r < MINV) begin
      q   = MINV[W_O-1:0];
      sat = 1'b1;
    end
  end
endmodule

module matvec_out_serializer #(
  parameter int R     = 2,
  parameter int W_Y   = 10,
  parameter int W_O   = 4,
  parameter int SHIFT = 2,
  parameter int RELU  = 0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [R-1:0][W_Y-1:0] s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [W_O-1:0]        m_data,
  output logic                  m_last,
  output logic                  m_sat
);
  localparam int IDXW = (R > 1) ? $clog2(R) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t                 state_q, state_d;
  logic [IDXW-1:0]        idx_q, idx_d;
  logic [R-1:0][W_Y-1:0]  hold_q;
  logic                   load;
  logic                   last_idx;

  logic [R-1:0][W_O-1:0]  lane_q;
  logic [R-1:0]           lane_sat;
  logic [W_O-1:0]         sel_d;
  logic                   sel_s;

  // Every element of the held vector is processed in parallel; the outputs
  // then only depend on registered state through the idx mux.
  for (genvar g = 0; g < R; g++) begin : g_lane
    matvec_out_serializer_lane #(
      .W_Y(W_Y), .W_O(W_O), .SHIFT(SHIFT), .RELU(RELU)
    ) u_lane (
      .y   (hold_q[g]),
      .q   (lane_q[g]),
      .sat (lane_sat[g])
    );
  end

  assign last_idx = (idx_q == IDXW'(R-1));

  always_comb begin
    sel_d = '0;
    sel_s = 1'b0;
    for (int i = 0; i < R; i++) begin
      if (idx_q == IDXW'(i)) begin
        sel_d = lane_q[i];
        sel_s = lane_sat[i];
      end
    end
  end

  assign m_valid = (state_q == SEND);
  assign m_data  = sel_d;
  assign m_last  = m_valid & last_idx;
  assign m_sat   = m_valid & sel_s;
  // Accepting on the last beat is what removes the inter-vector bubble.
  assign s_ready = (state_q == IDLE) | ((state_q == SEND) & last_idx & m_ready);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          state_d = SEND;
          idx_d   = '0;
          load    = 1'b1;
        end
      end
      SEND: begin
        if (m_ready) begin
          if (last_idx) begin
            if (s_valid) begin
              idx_d = '0;
              load  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (load) hold_q <= s_data;
    end
  end
endmodule

// File: tb/tb_matvec_out_serializer.sv
module tb_matvec_out_serializer;
  localparam int R     = 2;
  localparam int W_Y   = 10;
  localparam int W_O   = 4;
  localparam int SHIFT = 2;

  logic clk;
  logic rstn;

  logic                  s_valid, s_ready, m_valid, m_ready, m_last, m_sat;
  logic [R-1:0][W_Y-1:0] s_data;
  logic signed [W_O-1:0] m_data;

  logic                  r_s_valid, r_s_ready, r_m_valid, r_m_ready, r_m_last, r_m_sat;
  logic [R-1:0][W_Y-1:0] r_s_data;
  logic signed [W_O-1:0] r_m_data;

  int nchk = 0;
  int nerr = 0;

  matvec_out_serializer #(.R(R), .W_Y(W_Y), .W_O(W_O), .SHIFT(SHIFT), .RELU(0)) u_dut (
    .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .m_sat(m_sat)
  );

  matvec_out_serializer #(.R(R), .W_Y(W_Y), .W_O(W_O), .SHIFT(SHIFT), .RELU(1)) u_relu (
    .clk(clk), .rstn(rstn), .s_valid(r_s_valid), .s_ready(r_s_ready), .s_data(r_s_data),
    .m_valid(r_m_valid), .m_ready(r_m_ready), .m_data(r_m_data), .m_last(r_m_last),
    .m_sat(r_m_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: floor((v + 2^(SHIFT-1)) / 2^SHIFT), then clamp to W_O signed range.
  function automatic void ref_elem(input int y, input bit relu, output int d, output int s);
    int v, t, dv, lo, hi;
    v = y;
    if (relu && v < 0) v = 0;
    if (SHIFT > 0) begin
      dv = 1 << SHIFT;
      t  = v + dv / 2;
      v  = (t >= 0) ? t / dv : -((-t + dv - 1) / dv);
    end
    hi = (1 << (W_O - 1)) - 1;
    lo = -(1 << (W_O - 1));
    s  = 0;
    d  = v;
    if (v > hi) begin d = hi; s = 1; end
    else if (v < lo) begin d = lo; s = 1; end
  endfunction

  // One isolated vector on the RELU=0 instance, with a held beat to test stability.
  task automatic send_vec(input int y0, input int y1, input int ed0, input int es0,
                          input int ed1, input int es1, input string tag);
    s_valid   = 1'b1;
    s_data[0] = W_Y'(y0);
    s_data[1] = W_Y'(y1);
    m_ready   = 1'b0;
    #1;
    chk({tag, " s_ready_idle"}, s_ready, 1);
    chk({tag, " m_valid_before"}, m_valid, 0);
    step();
    s_valid   = 1'b0;
    s_data[0] = W_Y'($urandom);
    s_data[1] = W_Y'($urandom);
    #1;
    chk({tag, " m_valid_lat1"}, m_valid, 1);
    chk({tag, " d0"}, m_data, ed0);
    chk({tag, " sat0"}, m_sat, es0);
    chk({tag, " last0"}, m_last, 0);
    step();
    chk({tag, " d0_hold"}, m_data, ed0);
    chk({tag, " valid_hold"}, m_valid, 1);
    m_ready = 1'b1;
    #1;
    chk({tag, " s_ready_mid"}, s_ready, 0);
    step();
    chk({tag, " d1"}, m_data, ed1);
    chk({tag, " sat1"}, m_sat, es1);
    chk({tag, " last1"}, m_last, 1);
    chk({tag, " s_ready_last"}, s_ready, 1);
    step();
    chk({tag, " idle_valid"}, m_valid, 0);
    chk({tag, " idle_last"}, m_last, 0);
    m_ready = 1'b0;
  endtask

  // Random vectors with s_valid held high; scoreboard queue is the model of
  // what the block holds: non-empty = vector held, size 1 = last element shown.
  task automatic run_stream(input int nvec, input bit bp, input string tag);
    int qd[$], qs[$], ql[$];
    int vy[R];
    int sent, beats, cyc, first, lastc, d, s, pd, ps, pl;
    bit prev_stall;
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    sent = 0; beats = 0; cyc = 0; first = -1; lastc = -1;
    prev_stall = 1'b0; pd = 0; ps = 0; pl = 0;
    for (int i = 0; i < R; i++) vy[i] = int'($urandom_range(1023)) - 512;
    while ((sent < nvec || qd.size() > 0) && cyc < 400) begin
      m_ready = bp ? pat[cyc % 4] : 1'b1;
      s_valid = (sent < nvec);
      for (int i = 0; i < R; i++) s_data[i] = W_Y'(vy[i]);
      #1;
      chk({tag, " m_valid"}, m_valid, int'(qd.size() > 0));
      chk({tag, " s_ready"}, s_ready,
          int'(qd.size() == 0 || (qd.size() == 1 && m_ready)));
      if (prev_stall) begin
        chk({tag, " stall_valid"}, m_valid, 1);
        chk({tag, " stall_data"}, m_data, pd);
        chk({tag, " stall_sat"}, m_sat, ps);
        chk({tag, " stall_last"}, m_last, pl);
      end
      if (m_valid && m_ready && qd.size() > 0) begin
        chk({tag, " data"}, m_data, qd.pop_front());
        chk({tag, " sat"}, m_sat, qs.pop_front());
        chk({tag, " last"}, m_last, ql.pop_front());
        beats++;
        if (first < 0) first = cyc;
        lastc = cyc;
      end
      if (s_valid && s_ready) begin
        for (int i = 0; i < R; i++) begin
          ref_elem(vy[i], 1'b0, d, s);
          qd.push_back(d);
          qs.push_back(s);
          ql.push_back(int'(i == R - 1));
        end
        sent++;
        for (int i = 0; i < R; i++) vy[i] = int'($urandom_range(1023)) - 512;
      end
      prev_stall = m_valid && !m_ready;
      pd = m_data; ps = m_sat; pl = m_last;
      step();
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    chk({tag, " no_timeout"}, int'(cyc < 400), 1);
    chk({tag, " beats"}, beats, nvec * R);
    if (!bp) chk({tag, " span"}, lastc - first + 1, nvec * R);
    #1;
    chk({tag, " end_idle"}, m_valid, 0);
  endtask

  typedef struct {
    int y0, y1, d0, s0, d1, s1;
  } vec_t;

  initial begin
    vec_t tbl[8];
    tbl[0] = '{13, -7, 3, 0, -2, 0};
    tbl[1] = '{100, -100, 7, 1, -8, 1};
    tbl[2] = '{0, 0, 0, 0, 0, 0};
    tbl[3] = '{-1, 1, 0, 0, 0, 0};
    tbl[4] = '{2, -3, 1, 0, -1, 0};
    tbl[5] = '{29, -30, 7, 0, -7, 0};
    tbl[6] = '{30, -34, 7, 1, -8, 0};
    tbl[7] = '{511, -512, 7, 1, -8, 1};

    s_valid = 1'b0; m_ready = 1'b0; s_data = '0;
    r_s_valid = 1'b0; r_m_ready = 1'b0; r_s_data = '0;
    rstn = 1'b1;
    #2 rstn = 1'b0;
    #1;
    chk("rst m_valid", m_valid, 0);
    chk("rst s_ready", s_ready, 1);
    chk("rst m_last", m_last, 0);
    chk("rst m_sat", m_sat, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    step();

    for (int i = 0; i < 8; i++)
      send_vec(tbl[i].y0, tbl[i].y1, tbl[i].d0, tbl[i].s0, tbl[i].d1, tbl[i].s1,
               $sformatf("vec%0d", i));

    // ReLU instance: -7 clamps to 0, 6 rounds to 2
    r_s_valid   = 1'b1;
    r_s_data[0] = W_Y'(-7);
    r_s_data[1] = W_Y'(6);
    r_m_ready   = 1'b1;
    #1;
    chk("relu s_ready", r_s_ready, 1);
    step();
    r_s_valid = 1'b0;
    #1;
    chk("relu valid0", r_m_valid, 1);
    chk("relu d0", r_m_data, 0);
    chk("relu sat0", r_m_sat, 0);
    chk("relu last0", r_m_last, 0);
    step();
    chk("relu d1", r_m_data, 2);
    chk("relu sat1", r_m_sat, 0);
    chk("relu last1", r_m_last, 1);
    step();
    chk("relu idle", r_m_valid, 0);
    r_m_ready = 1'b0;

    run_stream(10, 1'b1, "bp");
    run_stream(8, 1'b0, "stream");

    // Async reset while holding a vector at element 0
    s_valid   = 1'b1;
    s_data[0] = W_Y'(100);
    s_data[1] = W_Y'(-100);
    m_ready   = 1'b0;
    step();
    s_valid = 1'b0;
    #1;
    chk("prerst m_valid", m_valid, 1);
    #2 rstn = 1'b0;
    #1;
    chk("midrst m_valid", m_valid, 0);
    chk("midrst s_ready", s_ready, 1);
    chk("midrst m_last", m_last, 0);
    chk("midrst m_sat", m_sat, 0);
    @(negedge clk) rstn = 1'b1;
    step();
    chk("postrst m_valid", m_valid, 0);
    send_vec(13, -7, 3, 0, -2, 0, "postrst");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
